adc_packet_builder: RTL and testbench
=====================================

ADC_PACKET_BUILDER -- requirements
Module: adc_packet_builder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2: packet FIFO entries; power of two, 2 to 8.
REQ-002 SHALL have parameter TS_W, default 16: timestamp counter width; fixed at 16 for packet packing.
REQ-003 SHALL have port clk210_p, input, 1: sole clock, 210 MHz, rising edge.
REQ-004 SHALL have port reset_p, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port sample_data_p, input, 16: ADC sample from the serial capture stage.
REQ-006 SHALL have port sample_valid_p, input, 1: one-cycle strobe; sample_data_p is valid in that cycle.
REQ-007 SHALL have port packet_rd_req_p, input, 1: one-cycle read request from memory map.
REQ-008 SHALL have port overflow_clr_p, input, 1: clears the sticky overflow flag.
REQ-009 SHALL have port data_packet_p, output, 80: registered packet returned on read.
REQ-010 SHALL have port packet_rd_ack_p, output, 1: one-cycle read acknowledge.
REQ-011 SHALL have port packet_er_p, output, 1: one-cycle error pulse for a read while the FIFO is empty.
REQ-012 SHALL have port packet_avail_p, output, 1: high while the FIFO is not empty.
REQ-013 SHALL have port overflow_p, output, 1: sticky flag set when a packet is dropped.

Function
REQ-014 SHALL pack each accepted sample into the assembler at slot index idx; slot k occupies bits [16k+15:16k]; the first sample goes in slot 0.
REQ-015 SHALL commit the assembled packet in the cycle the last slot is written; idx returns to 0 and no sample is lost at the boundary.
REQ-016 SHALL, on commit with the FIFO not full, write the packet to the FIFO at the write pointer, which then increments modulo FIFO_DEPTH.
REQ-017 SHALL, on commit with the FIFO full and no read in the same cycle, drop the packet, set overflow_p, and leave FIFO contents unchanged.
REQ-018 SHALL, when commit and read occur in the same cycle on a full FIFO, process the read first and accept the commit; no overflow occurs.
REQ-019 SHALL, on packet_rd_req_p with the FIFO not empty, load the head entry into data_packet_p and pulse packet_rd_ack_p in the next cycle (1-cycle latency), then advance the read pointer.
REQ-020 SHALL, on packet_rd_req_p with the FIFO empty, pulse packet_er_p in the next cycle, leaving data_packet_p unchanged and packet_rd_ack_p low.
REQ-021 SHALL hold data_packet_p between reads.
REQ-022 SHALL pulse packet_rd_ack_p and packet_er_p for exactly one cycle per request.
REQ-023 SHALL track occupancy with a count of width clog2(FIFO_DEPTH)+1; packet_avail_p = (count != 0).
REQ-024 SHALL clear overflow_p on overflow_clr_p; if a drop occurs in the same cycle, set takes priority.
REQ-025 SHALL ignore sample_valid_p, with no effect on idx, in the cycle reset_p is high.

Reset
REQ-026 SHALL, with reset_p high on a clock edge, clear idx, the assembler, FIFO pointers, count and the timestamp.
REQ-027 SHALL, on that reset edge, drive data_packet_p=0, packet_rd_ack_p=0, packet_er_p=0, packet_avail_p=0 and overflow_p=0.
REQ-028 SHALL discard a partially assembled packet when reset is asserted mid-operation; the first sample after reset lands in slot 0.
REQ-029 SHALL not clear FIFO storage contents on reset; they are unreadable until rewritten.

Configuration
REQ-030 SHALL, with ADC_PACKET_TIMESTAMP_EN defined, build each packet from 4 samples (slots 0-3, bits [63:0]) plus bits [79:64] holding a free-running 16-bit clk210_p cycle counter value captured when slot 0 is written. The counter wraps 0xFFFF to 0x0000.
REQ-031 SHALL, without ADC_PACKET_TIMESTAMP_EN, build each packet from 5 samples (slots 0-4), with no timestamp counter present.

Verification
REQ-032 SHALL cover: no macro; samples 0x0001..0x0005; read -> ack after 1 cycle, data_packet_p=0x0005_0004_0003_0002_0001.
REQ-033 SHALL cover: read with the FIFO empty after reset -> packet_er_p one cycle, packet_rd_ack_p=0, data_packet_p=0.
REQ-034 SHALL cover: FIFO_DEPTH=2; 3 packets with no reads -> overflow_p=1; two reads return packets 1 and 2; a third read -> packet_er_p.
REQ-035 SHALL cover: FIFO full; a read coincides with the 3rd commit -> overflow_p stays 0; subsequent reads return packets 2 and 3.
REQ-036 SHALL cover: 3 samples, then reset, then 5 samples 0xA..0xE -> packet=0x000E_000D_000C_000B_000A.
REQ-037 SHALL cover: macro defined; first sample at cycle 0xFFFE after reset; samples 0x11..0x14 -> bits[79:64]=0xFFFE, bits[63:0]=0x0014_0013_0012_0011; next packet timestamp wrapped.

Source files
------------

// File: rtl/adc_packet_builder.sv
// adc_packet_builder
//   Packs ADC samples into 80-bit packets and queues them in a small FIFO
//   that a memory-mapped reader drains one packet per request.
//
//   Build option ADC_PACKET_TIMESTAMP_EN:
//     undefined : 5 samples per packet, slots 0-4 fill bits [79:0].
//     defined   : 4 samples per packet in bits [63:0]; bits [79:64] hold a
//                 free-running 16-bit cycle count captured at slot 0.
//
//   Parameters
//     FIFO_DEPTH : packet FIFO entries, power of two, 2..8
//     TS_W       : timestamp width, fixed at 16
//
//   Ports
//     clk210_p        in   sole clock, rising edge
//     reset_p         in   synchronous active-high reset
//     sample_data_p   in   16-bit ADC sample
//     sample_valid_p  in   one-cycle sample strobe
//     packet_rd_req_p in   one-cycle read request
//     overflow_clr_p  in   clears sticky overflow
//     data_packet_p   out  packet returned by the last successful read
//     packet_rd_ack_p out  one-cycle acknowledge, cycle after the request
//     packet_er_p     out  one-cycle error, read of an empty FIFO
//     packet_avail_p  out  FIFO not empty
//     overflow_p      out  sticky, set when a completed packet is dropped
module adc_packet_builder #(
   parameter int FIFO_DEPTH = 2,
   parameter int TS_W       = 16
) (
   input  logic        clk210_p,
   input  logic        reset_p,
   input  logic [15:0] sample_data_p,
   input  logic        sample_valid_p,
   input  logic        packet_rd_req_p,
   input  logic        overflow_clr_p,
   output logic [79:0] data_packet_p,
   output logic        packet_rd_ack_p,
   output logic        packet_er_p,
   output logic        packet_avail_p,
   output logic        overflow_p
);

`ifdef ADC_PACKET_TIMESTAMP_EN
   localparam int NSLOT = 4;
`else
   localparam int NSLOT = 5;
`endif
   localparam int AW    = NSLOT * 16;
   localparam int PKT_W = 4 * 16 + TS_W;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int CW    = PW + 1;

   logic [2:0]       idx_q;
   logic [AW-1:0]    asm_q;
   logic [AW-1:0]    asm_next;
   logic [PKT_W-1:0] pkt;
   logic [PKT_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;

   logic last_slot;
   logic commit;
   logic fifo_empty;
   logic fifo_full;
   logic do_rd;
   logic do_wr;
   logic drop;

   // The sample arriving in the last slot is merged combinationally so the
   // packet commits in the same cycle and the next sample starts slot 0.
   always_comb begin
      asm_next = asm_q;
      for (int k = 0; k < NSLOT; k++) begin
         if (idx_q == 3'(k)) asm_next[k*16 +: 16] = sample_data_p;
      end
   end

`ifdef ADC_PACKET_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q;
   logic [TS_W-1:0] ts_cap_q;

   always_ff @(posedge clk210_p) begin
      if (reset_p) begin
         ts_q     <= '0;
         ts_cap_q <= '0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
         if (sample_valid_p && idx_q == 3'd0) ts_cap_q <= ts_q;
      end
   end

   // Slot 0 is never the last slot here, so the captured stamp is stable at commit.
   assign pkt = {ts_cap_q, asm_next};
`else
   assign pkt = asm_next;
`endif

   assign last_slot  = (idx_q == 3'(NSLOT - 1));
   assign commit     = sample_valid_p && last_slot && !reset_p;
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
   assign do_rd      = packet_rd_req_p && !fifo_empty && !reset_p;
   // A read in the same cycle frees a slot for a commit into a full FIFO.
   assign do_wr      = commit && (!fifo_full || do_rd);
   assign drop       = commit && fifo_full && !do_rd;

   assign packet_avail_p = !fifo_empty;

   // Storage is deliberately not reset; stale entries are unreachable
   // because count and pointers are.
   always_ff @(posedge clk210_p) begin
      if (do_wr) mem[wr_ptr_q] <= pkt;
   end

   always_ff @(posedge clk210_p) begin
      if (reset_p) begin
         idx_q           <= '0;
         asm_q           <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
         data_packet_p   <= '0;
         packet_rd_ack_p <= 1'b0;
         packet_er_p     <= 1'b0;
         overflow_p      <= 1'b0;
      end else begin
         packet_rd_ack_p <= do_rd;
         packet_er_p     <= packet_rd_req_p && fifo_empty;
         if (sample_valid_p) begin
            asm_q <= asm_next;
            idx_q <= last_slot ? 3'd0 : idx_q + 3'd1;
         end
         if (do_rd) begin
            data_packet_p <= mem[rd_ptr_q];
            rd_ptr_q      <= rd_ptr_q + PW'(1);
         end
         if (do_wr) wr_ptr_q <= wr_ptr_q + PW'(1);
         count_q <= count_q + CW'(do_wr) - CW'(do_rd);
         if (drop)                overflow_p <= 1'b1;
         else if (overflow_clr_p) overflow_p <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adc_packet_builder.sv
module tb_adc_packet_builder;

   localparam int DEPTH = 2;
`ifdef ADC_PACKET_TIMESTAMP_EN
   localparam int NSLOT = 4;
`else
   localparam int NSLOT = 5;
`endif

   logic        clk210_p = 1'b0;
   logic        reset_p = 1'b0;
   logic [15:0] sample_data_p = '0;
   logic        sample_valid_p = 1'b0;
   logic        packet_rd_req_p = 1'b0;
   logic        overflow_clr_p = 1'b0;
   logic [79:0] data_packet_p;
   logic        packet_rd_ack_p;
   logic        packet_er_p;
   logic        packet_avail_p;
   logic        overflow_p;

   adc_packet_builder #(.FIFO_DEPTH(DEPTH), .TS_W(16)) dut (
      .clk210_p        (clk210_p),
      .reset_p         (reset_p),
      .sample_data_p   (sample_data_p),
      .sample_valid_p  (sample_valid_p),
      .packet_rd_req_p (packet_rd_req_p),
      .overflow_clr_p  (overflow_clr_p),
      .data_packet_p   (data_packet_p),
      .packet_rd_ack_p (packet_rd_ack_p),
      .packet_er_p     (packet_er_p),
      .packet_avail_p  (packet_avail_p),
      .overflow_p      (overflow_p)
   );

   always #5 clk210_p = ~clk210_p;

   typedef struct packed {
      logic        ack;
      logic        er;
      logic [79:0] data;
   } rd_exp_t;

   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   logic [79:0] m_q[$];
   rd_exp_t     sb_q[$];
   int          m_idx = 0;
   logic [79:0] m_asm = '0;
   logic [15:0] m_ts = '0;
   logic [15:0] m_ts_cap = '0;
   logic [79:0] m_data = '0;
   logic        m_ovf = 1'b0;

   task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, advance the model, then check outputs #1 after the edge.
   task automatic tick(input logic sv, input logic [15:0] sd, input logic rd,
                       input logic clr, input logic rst);
      rd_exp_t     e;
      logic [79:0] p;
      sample_valid_p  = sv;
      sample_data_p   = sd;
      packet_rd_req_p = rd;
      overflow_clr_p  = clr;
      reset_p         = rst;
      e = '{ack: 1'b0, er: 1'b0, data: m_data};
      if (rst) begin
         m_q.delete();
         m_idx  = 0;
         m_asm  = '0;
         m_ts   = '0;
         m_data = '0;
         m_ovf  = 1'b0;
         e.data = '0;
      end else begin
         if (rd) begin
            if (m_q.size() != 0) begin
               m_data = m_q.pop_front();
               e.ack  = 1'b1;
               e.data = m_data;
            end else begin
               e.er = 1'b1;
            end
         end
         if (clr) m_ovf = 1'b0;
         if (sv) begin
            if (m_idx == 0) m_ts_cap = m_ts;
            m_asm[m_idx*16 +: 16] = sd;
            if (m_idx == NSLOT - 1) begin
`ifdef ADC_PACKET_TIMESTAMP_EN
               p = {m_ts_cap, m_asm[63:0]};
`else
               p = m_asm;
`endif
               if (m_q.size() < DEPTH) m_q.push_back(p);
               else m_ovf = 1'b1;
               m_idx = 0;
            end else begin
               m_idx++;
            end
         end
         m_ts = m_ts + 16'd1;
      end
      sb_q.push_back(e);
      @(posedge clk210_p);
      #1;
      e = sb_q.pop_front();
      chk("ack",   80'(packet_rd_ack_p), 80'(e.ack));
      chk("er",    80'(packet_er_p),     80'(e.er));
      chk("data",  data_packet_p,        e.data);
      chk("avail", 80'(packet_avail_p),  80'(m_q.size() != 0));
      chk("ovf",   80'(overflow_p),      80'(m_ovf));
   endtask

   task automatic idle();
      tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic rd();
      tick(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      tick(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
   endtask

   // Sends one full packet of consecutive samples base, base+1, ...
   task automatic send_pkt(input logic [15:0] base);
      for (int i = 0; i < NSLOT; i++) tick(1'b1, base + 16'(i), 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      // reset state
      do_reset();
      chk("rst_data", data_packet_p, 80'h0);

      // empty read after reset
      rd();
      chk("empty_er", 80'(packet_er_p), 80'h1);
      chk("empty_data", data_packet_p, 80'h0);
      idle();

      // basic packet
      send_pkt(16'h0001);
      rd();
      chk("basic_ack", 80'(packet_rd_ack_p), 80'h1);
`ifndef ADC_PACKET_TIMESTAMP_EN
      chk("basic_pkt", data_packet_p, 80'h0005_0004_0003_0002_0001);
`endif
      idle();
      idle();

      // overflow: three packets into a two-deep FIFO
      do_reset();
      send_pkt(16'h0100);
      send_pkt(16'h0200);
      send_pkt(16'h0300);
      chk("ovf_set", 80'(overflow_p), 80'h1);
      rd();
`ifndef ADC_PACKET_TIMESTAMP_EN
      chk("ovf_rd1", data_packet_p, 80'h0104_0103_0102_0101_0100);
`endif
      rd();
`ifndef ADC_PACKET_TIMESTAMP_EN
      chk("ovf_rd2", data_packet_p, 80'h0204_0203_0202_0201_0200);
`endif
      rd();
      chk("ovf_er", 80'(packet_er_p), 80'h1);
      tick(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      chk("ovf_clr", 80'(overflow_p), 80'h0);

      // full FIFO, read coincides with the third commit
      send_pkt(16'h1000);
      send_pkt(16'h2000);
      for (int i = 0; i < NSLOT - 1; i++) tick(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0, 1'b0);
      tick(1'b1, 16'h3000 + 16'(NSLOT - 1), 1'b1, 1'b0, 1'b0);
      chk("rdcommit_ovf", 80'(overflow_p), 80'h0);
      rd();
      rd();
`ifndef ADC_PACKET_TIMESTAMP_EN
      chk("rdcommit_pkt3", data_packet_p, 80'h3004_3003_3002_3001_3000);
`endif

      // drop and clear in the same cycle: set wins
      send_pkt(16'h4000);
      send_pkt(16'h5000);
      for (int i = 0; i < NSLOT - 1; i++) tick(1'b1, 16'h6000 + 16'(i), 1'b0, 1'b0, 1'b0);
      tick(1'b1, 16'h6000 + 16'(NSLOT - 1), 1'b0, 1'b1, 1'b0);
      chk("setwins", 80'(overflow_p), 80'h1);
      rd();
      rd();

      // partial packet discarded by reset
      for (int i = 0; i < 3; i++) tick(1'b1, 16'h0077, 1'b0, 1'b0, 1'b0);
      do_reset();
      for (int i = 0; i < NSLOT; i++) tick(1'b1, 16'h000A + 16'(i), 1'b0, 1'b0, 1'b0);
      rd();
`ifndef ADC_PACKET_TIMESTAMP_EN
      chk("midrst_pkt", data_packet_p, 80'h000E_000D_000C_000B_000A);
`endif

      // reset with a sample strobe present must not advance the slot index
      tick(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b1);
      send_pkt(16'h0B00);
      rd();

      // random traffic against the model
      for (int i = 0; i < 300; i++) begin
         tick(($urandom_range(0, 3) != 0), 16'($urandom),
              ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), 1'b0);
      end
      while (m_q.size() != 0) rd();
      rd();

`ifdef ADC_PACKET_TIMESTAMP_EN
      // timestamp capture and wrap
      do_reset();
      for (int i = 0; i < 70000 && m_ts != 16'hFFFE; i++) idle();
      chk("ts_reach", 80'(m_ts), 80'hFFFE);
      for (int i = 0; i < 4; i++) tick(1'b1, 16'h0011 + 16'(i), 1'b0, 1'b0, 1'b0);
      rd();
      chk("ts_stamp", 80'(data_packet_p[79:64]), 80'hFFFE);
      chk("ts_samples", 80'(data_packet_p[63:0]), 80'h0014_0013_0012_0011);
      for (int i = 0; i < 4; i++) tick(1'b1, 16'h0021 + 16'(i), 1'b0, 1'b0, 1'b0);
      rd();
      chk("ts_wrap", 80'(data_packet_p[79:64]), 80'h0003);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
